// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: oversample tick, byte handshake, show-ahead FIFO.
// Optional idle timeout enabled by defining UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int N             = 8,
  parameter int DEPTH         = 4,
  parameter int DIV_W         = 16,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           divisor,
  output logic                       rx_en,
  input  logic                       rx_ready,
  input  logic [N-1:0]               rx_data,
  output logic                       ready_clr,
  input  logic                       rd_en,
  output logic [N-1:0]               rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic                       rx_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {WAIT, CLEAR} state_t;

  state_t           state;
  logic [DIV_W-1:0] tick_cnt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [N-1:0]     mem [DEPTH];
  logic [CW-1:0]    cnt_nxt;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;

  // tick generator
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      tick_cnt <= '0;
      rx_en    <= 1'b0;
    end else if (divisor <= DIV_W'(1) ||
                 tick_cnt >= divisor - DIV_W'(1)) begin
      tick_cnt <= '0;
      rx_en    <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
      rx_en    <= 1'b0;
    end
  end

  // capture FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT;
      ready_clr <= 1'b0;
    end else begin
      unique case (state)
        WAIT: begin
          if (rx_ready) begin
            state     <= CLEAR;
            ready_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= WAIT;
          ready_clr <= 1'b0;
        end
        default: begin
          state     <= WAIT;
          ready_clr <= 1'b0;
        end
      endcase
    end
  end

  // a full FIFO still accepts a byte when the same edge pops
  assign push_req = (state == WAIT) && rx_ready;
  assign pop      = rd_en && !empty;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)
      cnt_nxt = count + CW'(1);
    else if (!push && pop)
      cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS+1);

  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else if (push || pop || empty) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else if (rx_en && to_cnt != TW'(TIMEOUT_TICKS)) begin
      to_cnt     <= to_cnt + TW'(1);
      rx_timeout <= (to_cnt + TW'(1) == TW'(TIMEOUT_TICKS));
    end
  end
`else
  // feature absent: constant-false expression keeps the parameter referenced
  assign rx_timeout = (TIMEOUT_TICKS < 0);
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based FIFO model checked every cycle,
// plus directed literal checks for ticks, handshake, order and overrun.
module tb_uart_rx_ctrl;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [DIV_W-1:0] divisor;
  logic             rx_en;
  logic             rx_ready;
  logic [N-1:0]     rx_data;
  logic             ready_clr;
  logic             rd_en;
  logic [N-1:0]     rd_data;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             overrun;
  logic             overrun_clr;
  logic             rx_timeout;

  int ncmp = 0;
  int nbad = 0;
  bit chk_on = 0;

  uart_rx_ctrl #(.N(N), .DEPTH(DEPTH), .DIV_W(DIV_W), .TIMEOUT_TICKS(64)) dut (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .rx_en(rx_en), .rx_ready(rx_ready), .rx_data(rx_data),
    .ready_clr(ready_clr), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overrun(overrun),
    .overrun_clr(overrun_clr), .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: a byte queue, a sticky drop flag and a pending-acknowledge flag
  logic [N-1:0] mq[$];
  bit m_ovr;
  bit m_ack;

  always @(posedge clk) begin
    bit pr;
    bit set;
    logic [N-1:0] tmp;
    if (reset) begin
      mq.delete();
      m_ovr = 0;
      m_ack = 0;
    end else begin
      pr  = rx_ready && !m_ack;
      set = 0;
      if (rd_en && mq.size() > 0)
        tmp = mq.pop_front();
      if (pr) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data);
        else set = 1;
      end
      if (set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      m_ack = pr;
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (chk_on) begin
      chk("m_ready_clr", ready_clr, m_ack);
      chk("m_count", count, mq.size());
      chk("m_empty", empty, mq.size() == 0);
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_rd_data", rd_data, mq.size() > 0 ? mq[0] : 8'h00);
      chk("m_overrun", overrun, m_ovr);
`ifndef UART_RX_CTRL_TIMEOUT_EN
      chk("m_rx_timeout", rx_timeout, 0);
`endif
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [N-1:0] b);
    bit got = 0;
    rx_ready = 1;
    rx_data  = b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_clr) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("send_ack_seen", 0, 1);
    rx_ready = 0;
    @(negedge clk);
    chk("ready_clr_width", ready_clr, 0);
  endtask

  task automatic pop_expect(string nm, logic [N-1:0] exp);
    chk(nm, rd_data, exp);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  initial begin
    int nt;
    int last;
    reset = 1; enable = 0; divisor = '0;
    rx_ready = 0; rx_data = '0; rd_en = 0; overrun_clr = 0;
    chk_on = 1;
    cyc(2);
    reset = 0;
    cyc(1);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", rx_timeout, 0);

    // divisor 5: one tick per 5 cycles
    divisor = 16'd5;
    enable  = 1;
    cyc(2);
    nt = 0;
    last = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rx_en) begin
        if (last >= 0) chk("div5_gap", i - last, 5);
        last = i;
        nt++;
      end
    end
    chk("div5_ticks", nt, 5);
    divisor = 16'd0;
    cyc(1);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_en) nt++;
    end
    chk("div0_ticks", nt, 10);
    divisor = 16'd1;
    cyc(1);
    nt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_en) nt++;
    end
    chk("div1_ticks", nt, 10);
    enable = 0;
    cyc(1);
    chk("disable_rx_en", rx_en, 0);

    // handshake
    send(8'hA5);
    chk("hs_count", count, 1);
    chk("hs_rd_data", rd_data, 8'hA5);
    chk("hs_empty", empty, 0);
    pop_expect("hs_pop", 8'hA5);
    chk("hs_empty_after", empty, 1);

    // ordering
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("ord_count", count, 3);
    pop_expect("ord_pop0", 8'h11);
    pop_expect("ord_pop1", 8'h22);
    pop_expect("ord_pop2", 8'h33);
    chk("ord_empty", empty, 1);
    chk("ord_rd_data0", rd_data, 0);
    rd_en = 1;
    cyc(1);
    rd_en = 0;
    chk("ord_pop_empty_cnt", count, 0);

    // overrun by a fifth byte
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("ovr_full", full, 1);
    chk("ovr_count", count, 4);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", 8'(i));
    chk("ovr_drained", empty, 1);
    overrun_clr = 1;
    cyc(1);
    overrun_clr = 0;
    chk("ovr_cleared", overrun, 0);

    // fifth byte with a concurrent pop
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
    rx_ready = 1; rx_data = 8'h44; rd_en = 1;
    cyc(1);
    rx_ready = 0; rd_en = 0;
    cyc(1);
    chk("pp_overrun", overrun, 0);
    chk("pp_count", count, 4);
    chk("pp_head", rd_data, 8'h41);

    // set and clear together: set wins
    rx_ready = 1; rx_data = 8'h55; overrun_clr = 1;
    cyc(1);
    rx_ready = 0; overrun_clr = 0;
    cyc(1);
    chk("setclr_overrun", overrun, 1);
    overrun_clr = 1;
    cyc(1);
    overrun_clr = 0;
    chk("setclr_then_clr", overrun, 0);

    // reset mid-run
    pop_expect("mr_pop", 8'h41);
    chk("mr_count3", count, 3);
    enable = 1; divisor = 16'd1;
    rx_ready = 1; rx_data = 8'h66;
    cyc(1);
    reset = 1; rx_ready = 0;
    cyc(1);
    reset = 0; enable = 0;
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_rx_en", rx_en, 0);
    chk("mr_ready_clr", ready_clr, 0);
    chk("mr_overrun", overrun, 0);

    // idle timeout
    enable = 1; divisor = 16'd1;
    send(8'h77);
    cyc(60);
    chk("to_early", rx_timeout, 0);
    cyc(10);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    chk("to_fired", rx_timeout, 1);
`else
    chk("to_absent", rx_timeout, 0);
`endif
    pop_expect("to_pop", 8'h77);
    chk("to_cleared", rx_timeout, 0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
